// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  // True for the ops that occupy the unit for multiple cycles.
  function automatic logic is_start_op(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 product and quotient/remainder for the MD sequencer.
// Latency: zero cycles, purely combinational.
// Backpressure: none; results are sampled by the owner when it chooses.
module md_arith
  import md_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        is_signed,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic        a_neg;
  logic        b_neg;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_b;
  logic [31:0] mag_q;
  logic [31:0] mag_r;

  assign a_neg = is_signed & op_a[31];
  assign b_neg = is_signed & op_b[31];

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then exact.
  assign ext_a = {{32{a_neg}}, op_a};
  assign ext_b = {{32{b_neg}}, op_b};
  assign prod  = ext_a * ext_b;

  // Divide magnitudes and reapply signs: truncation toward zero, remainder follows
  // the dividend. 0x80000000 / -1 naturally yields 0x80000000 rem 0 this way.
  assign abs_a = a_neg ? (32'd0 - op_a) : op_a;
  assign abs_b = b_neg ? (32'd0 - op_b) : op_b;
  // Zero divisor is substituted so the result stays defined; the owner skips the write.
  assign div_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
  assign mag_q = abs_a / div_b;
  assign mag_r = abs_a % div_b;
  assign quot  = (a_neg ^ b_neg) ? (32'd0 - mag_q) : mag_q;
  assign rem   = a_neg ? (32'd0 - mag_r) : mag_r;

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer owning HI/LO, with fixed multi-cycle busy modelling.
// Latency: MULT_CYCLES/DIV_CYCLES busy cycles, result visible the cycle after; MTHI/MTLO one cycle.
// Backpressure: MD_Stall holds an MD op in D while a start is in E or the unit is busy.
module md_unit_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_RsVal,
  input  logic [31:0] E_RtVal,
  input  logic        D_IsMD,
  output logic        E_Start,
  output logic        MD_Busy,
  output logic        MD_Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDRead
);

  md_state_t   state;
  logic [3:0]  cnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        is_signed;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;

  md_arith u_arith (
    .op_a      (op_a),
    .op_b      (op_b),
    .is_signed (is_signed),
    .prod      (prod),
    .quot      (quot),
    .rem       (rem)
  );

  assign E_Start  = is_start_op(E_MDOp) && (state == ST_IDLE);
  assign MD_Busy  = (state != ST_IDLE);
  assign MD_Stall = D_IsMD && (E_Start || MD_Busy);
  assign E_MDRead = (E_MDOp == MD_MFHI) ? HI :
                    (E_MDOp == MD_MFLO) ? LO : 32'd0;

  // Sequencer: accept ops only in IDLE, count down, commit results on the last busy edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      is_signed <= 1'b0;
      HI        <= 32'd0;
      LO        <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_start_op(E_MDOp)) begin
            op_a      <= E_RsVal;
            op_b      <= E_RtVal;
            is_signed <= (E_MDOp == MD_MULT) || (E_MDOp == MD_DIV);
            if ((E_MDOp == MD_MULT) || (E_MDOp == MD_MULTU)) begin
              cnt   <= 4'(MULT_CYCLES);
              state <= ST_MUL;
            end else begin
              cnt   <= 4'(DIV_CYCLES);
              state <= ST_DIV;
            end
          end else if (E_MDOp == MD_MTHI) begin
            HI <= E_RsVal;
          end else if (E_MDOp == MD_MTLO) begin
            LO <= E_RsVal;
          end
        end
        ST_MUL: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            HI    <= prod[63:32];
            LO    <= prod[31:0];
            state <= ST_IDLE;
          end
        end
        ST_DIV: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            // Divide by zero still burns the full latency but leaves HI/LO alone.
            if (op_b != 32'd0) begin
              HI <= rem;
              LO <= quot;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: HI/LO results, busy/stall timing, reset abort.
// Latency: inputs change on the falling edge, outputs sampled 1 time unit later.
// Backpressure: n/a; every wait on the DUT is bounded by a cycle budget.
module tb_md_unit_ctrl;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  e_mdop;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        d_is_md;
  logic        e_start;
  logic        md_busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] e_mdread;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .E_MDOp   (e_mdop),
    .E_RsVal  (rs),
    .E_RtVal  (rt),
    .D_IsMD   (d_is_md),
    .E_Start  (e_start),
    .MD_Busy  (md_busy),
    .MD_Stall (md_stall),
    .HI       (hi),
    .LO       (lo),
    .E_MDRead (e_mdread)
  );

  // Advance to the next falling edge, apply one cycle of inputs, settle.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic dmd);
    @(negedge clk);
    e_mdop  = op;
    rs      = a;
    rt      = b;
    d_is_md = dmd;
    #1;
  endtask

  // Count consecutive busy cycles starting with the current one, with idle inputs.
  task automatic count_busy(output int n);
    n = 0;
    while (md_busy === 1'b1 && n < 40) begin
      n++;
      drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    vecs++; if (md_busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", md_busy); end
    vecs++; if (e_start !== 1'b0) begin errs++; $display("FAIL reset_start: got %b expected 0", e_start); end
    vecs++; if (md_stall !== 1'b0) begin errs++; $display("FAIL reset_stall: got %b expected 0", md_stall); end
    vecs++; if (hi !== 32'd0) begin errs++; $display("FAIL reset_hi: got %h expected 0", hi); end
    vecs++; if (lo !== 32'd0) begin errs++; $display("FAIL reset_lo: got %h expected 0", lo); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mult;
    int n;
    drive(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
    vecs++; if (e_start !== 1'b1) begin errs++; $display("FAIL mult_start: got %b expected 1", e_start); end
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    count_busy(n);
    vecs++; if (n !== MC) begin errs++; $display("FAIL mult_busy_cycles: got %0d expected %0d", n, MC); end
    vecs++; if (hi !== 32'hFFFF_FFFF) begin errs++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    vecs++; if (lo !== 32'hFFFF_FFFE) begin errs++; $display("FAIL mult_lo: got %h expected fffffffe", lo); end
    drive(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    count_busy(n);
    vecs++; if (n !== MC) begin errs++; $display("FAIL multu_busy_cycles: got %0d expected %0d", n, MC); end
    vecs++; if (hi !== 32'h0000_0001) begin errs++; $display("FAIL multu_hi: got %h expected 00000001", hi); end
    vecs++; if (lo !== 32'hFFFF_FFFE) begin errs++; $display("FAIL multu_lo: got %h expected fffffffe", lo); end
  endtask

  task automatic test_div;
    int n;
    drive(MD_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    count_busy(n);
    vecs++; if (n !== DC) begin errs++; $display("FAIL divu_busy_cycles: got %0d expected %0d", n, DC); end
    vecs++; if (lo !== 32'h7FFF_FFFC) begin errs++; $display("FAIL divu_lo: got %h expected 7ffffffc", lo); end
    vecs++; if (hi !== 32'h0000_0001) begin errs++; $display("FAIL divu_hi: got %h expected 00000001", hi); end
    drive(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    count_busy(n);
    vecs++; if (n !== DC) begin errs++; $display("FAIL div_busy_cycles: got %0d expected %0d", n, DC); end
    vecs++; if (lo !== 32'hFFFF_FFFD) begin errs++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    vecs++; if (hi !== 32'hFFFF_FFFF) begin errs++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
    drive(MD_DIVU, 32'd7, 32'd0, 1'b0);
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    count_busy(n);
    vecs++; if (n !== DC) begin errs++; $display("FAIL div0_busy_cycles: got %0d expected %0d", n, DC); end
    vecs++; if (lo !== 32'hFFFF_FFFD) begin errs++; $display("FAIL div0_lo: got %h expected fffffffd", lo); end
    vecs++; if (hi !== 32'hFFFF_FFFF) begin errs++; $display("FAIL div0_hi: got %h expected ffffffff", hi); end
  endtask

  task automatic test_busy_violation;
    drive(MD_MULT, 32'd2, 32'd3, 1'b0);                // cycle 0
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);                // cycle 1
    drive(MD_MULT, 32'd7, 32'd9, 1'b0);                // cycle 2
    vecs++; if (e_start !== 1'b0) begin errs++; $display("FAIL viol_start: got %b expected 0", e_start); end
    drive(MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);        // cycle 3
    drive(MD_DIV, 32'd5, 32'd1, 1'b0);                 // cycle 4
    vecs++; if (hi !== 32'hFFFF_FFFF) begin errs++; $display("FAIL viol_mthi_ignored: got %h expected ffffffff", hi); end
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);                // cycle 5
    vecs++; if (md_busy !== 1'b1) begin errs++; $display("FAIL viol_busy_c5: got %b expected 1", md_busy); end
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);                // cycle 6
    vecs++; if (md_busy !== 1'b0) begin errs++; $display("FAIL viol_busy_c6: got %b expected 0", md_busy); end
    vecs++; if (hi !== 32'd0) begin errs++; $display("FAIL viol_hi: got %h expected 00000000", hi); end
    vecs++; if (lo !== 32'd6) begin errs++; $display("FAIL viol_lo: got %h expected 00000006", lo); end
  endtask

  task automatic test_div_overflow;
    int n;
    drive(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    count_busy(n);
    vecs++; if (n !== DC) begin errs++; $display("FAIL ovf_busy_cycles: got %0d expected %0d", n, DC); end
    vecs++; if (lo !== 32'h8000_0000) begin errs++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
    vecs++; if (hi !== 32'd0) begin errs++; $display("FAIL ovf_hi: got %h expected 00000000", hi); end
  endtask

  task automatic test_stall;
    int n;
    // MFLO sits in D behind a MULT in E.
    drive(MD_MULT, 32'd3, 32'd4, 1'b1);
    n = 0;
    while (md_stall === 1'b1 && n < 40) begin
      n++;
      drive(MD_NONE, 32'd0, 32'd0, 1'b1);
    end
    vecs++; if (n !== MC + 1) begin errs++; $display("FAIL stall_cycles: got %0d expected %0d", n, MC + 1); end
    vecs++; if (lo !== 32'd12) begin errs++; $display("FAIL stall_lo_ready: got %h expected 0000000c", lo); end
    drive(MD_MFLO, 32'd0, 32'd0, 1'b0);
    vecs++; if (e_mdread !== 32'd12) begin errs++; $display("FAIL stall_mflo_read: got %h expected 0000000c", e_mdread); end
    // A non-MD instruction in D never stalls, even while busy.
    drive(MD_MULT, 32'd1, 32'd1, 1'b0);
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    vecs++; if (md_stall !== 1'b0 || md_busy !== 1'b1) begin errs++;
      $display("FAIL nonmd_stall: got stall=%b busy=%b expected stall=0 busy=1", md_stall, md_busy); end
    count_busy(n);
  endtask

  task automatic test_mthi_mtlo;
    drive(MD_MTHI, 32'h1234_5678, 32'd0, 1'b1);
    vecs++; if (md_stall !== 1'b0) begin errs++; $display("FAIL mthi_stall: got %b expected 0", md_stall); end
    drive(MD_MFHI, 32'd0, 32'd0, 1'b0);
    vecs++; if (e_mdread !== 32'h1234_5678) begin errs++; $display("FAIL mfhi_read: got %h expected 12345678", e_mdread); end
    drive(MD_MTLO, 32'hCAFE_F00D, 32'd0, 1'b1);
    drive(MD_MFLO, 32'd0, 32'd0, 1'b0);
    vecs++; if (e_mdread !== 32'hCAFE_F00D) begin errs++; $display("FAIL mflo_read: got %h expected cafef00d", e_mdread); end
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    vecs++; if (e_mdread !== 32'd0) begin errs++; $display("FAIL none_read: got %h expected 00000000", e_mdread); end
  endtask

  task automatic test_reset_mid_div;
    int n;
    drive(MD_DIV, 32'd100, 32'd7, 1'b0);               // cycle 0
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);                // cycle 1
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);                // cycle 2
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);                // cycle 3
    reset_n = 1'b0;
    #1;
    vecs++; if (md_busy !== 1'b0) begin errs++; $display("FAIL rst_mid_busy: got %b expected 0", md_busy); end
    vecs++; if (hi !== 32'd0) begin errs++; $display("FAIL rst_mid_hi: got %h expected 00000000", hi); end
    vecs++; if (lo !== 32'd0) begin errs++; $display("FAIL rst_mid_lo: got %h expected 00000000", lo); end
    @(negedge clk);
    reset_n = 1'b1;
    drive(MD_MULT, 32'd5, 32'd6, 1'b0);
    vecs++; if (e_start !== 1'b1) begin errs++; $display("FAIL rst_mult_start: got %b expected 1", e_start); end
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    count_busy(n);
    vecs++; if (n !== MC) begin errs++; $display("FAIL rst_mult_busy: got %0d expected %0d", n, MC); end
    vecs++; if (lo !== 32'd30 || hi !== 32'd0) begin errs++;
      $display("FAIL rst_mult_result: got hi=%h lo=%h expected hi=00000000 lo=0000001e", hi, lo); end
  endtask

  initial begin
    reset_n = 1'b1;
    e_mdop  = MD_NONE;
    rs      = 32'd0;
    rt      = 32'd0;
    d_is_md = 1'b0;
    #2;
    test_reset;
    test_mult;
    test_div;
    test_busy_violation;
    test_div_overflow;
    test_stall;
    test_mthi_mtlo;
    test_reset_mid_div;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
